// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 pipeline control slice.
// Holds the instruction codes, register IDs and status codes observed at the stage boundaries,
// plus the state encoding of the pipeline control sequencer.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register IDs
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Status codes
  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StRetWait = 2'd1,
    StHalt    = 2'd2
  } state_e;

endpackage

// File: rtl/y86_sat_cnt.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, clears the count
//   inc_i  - add one this cycle (ignored once the count is all-ones)
//   cnt_o  - current count
module y86_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 pipeline.
// Decodes load/use, mispredict, ret and exception conditions from the stage boundaries and
// drives the stall/bubble controls of the F/D/E/M/W registers. Owns the ret-drain sequencer,
// the halt state and three saturating performance counters.
// Ports:
//   clk_i, rst_i                  - clock, synchronous active-high reset
//   D_icode_i, d_srcA_i, d_srcB_i - instruction in decode and its source registers
//   E_icode_i, E_dstM_i, e_Cnd_i  - instruction in execute, its load target, branch outcome
//   m_stat_i, W_stat_i            - status from memory stage and in the W register
//   F_stall_o .. W_stall_o        - pipeline register controls (combinational)
//   halted_o                      - unit is in the halt state
//   cycle_cnt_o, stall_cnt_o, bubble_cnt_o - saturating performance counters
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RET_BUBBLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       W_stat_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  // The cycle that detects the ret is the first bubble, so the counter holds the remaining ones.
  localparam logic [1:0] RetLoad = 2'(RET_BUBBLES - 1);

  state_e     r_state, w_state_d;
  logic [1:0] r_ret_cnt, w_ret_cnt_d;

  logic w_lu, w_mp, w_exc_m, w_exc_w;
  logic w_cyc_inc, w_stall_inc, w_bub_inc;

  assign w_lu = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign w_mp    = (E_icode_i == IJXX) && !e_Cnd_i;
  assign w_exc_m = (m_stat_i != SAOK);
  assign w_exc_w = (W_stat_i != SAOK);

  always_comb begin
    F_stall_o   = 1'b0;
    D_stall_o   = 1'b0;
    D_bubble_o  = 1'b0;
    E_bubble_o  = 1'b0;
    M_bubble_o  = 1'b0;
    W_stall_o   = 1'b0;
    halted_o    = 1'b0;
    w_cyc_inc   = 1'b0;
    w_stall_inc = 1'b0;
    w_bub_inc   = 1'b0;
    w_state_d   = r_state;
    w_ret_cnt_d = r_ret_cnt;

    if (rst_i) begin
      D_bubble_o  = 1'b1;
      E_bubble_o  = 1'b1;
      M_bubble_o  = 1'b1;
      w_state_d   = StRun;
      w_ret_cnt_d = 2'd0;
    end else begin
      case (r_state)
        StRun: begin
          w_cyc_inc = 1'b1;
          if (w_exc_w) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
            W_stall_o  = 1'b1;
            w_state_d  = StHalt;
          end else begin
            if (w_mp) begin
              // Squashes D as well, so a ret there never starts its drain.
              D_bubble_o = 1'b1;
              E_bubble_o = 1'b1;
              w_bub_inc  = 1'b1;
            end else if (w_lu) begin
              // A ret in D is held here and starts its drain once the hazard clears.
              F_stall_o   = 1'b1;
              D_stall_o   = 1'b1;
              E_bubble_o  = 1'b1;
              w_stall_inc = 1'b1;
            end else if (D_icode_i == IRET) begin
              F_stall_o  = 1'b1;
              D_bubble_o = 1'b1;
              w_bub_inc  = 1'b1;
              if (RetLoad != 2'd0) begin
                w_ret_cnt_d = RetLoad;
                w_state_d   = StRetWait;
              end
            end
            // Faulting instruction in M: keep its store out of memory state.
            if (w_exc_m) begin
              M_bubble_o = 1'b1;
            end
          end
        end
        StRetWait: begin
          w_cyc_inc = 1'b1;
          if (w_exc_w) begin
            F_stall_o   = 1'b1;
            D_stall_o   = 1'b1;
            E_bubble_o  = 1'b1;
            M_bubble_o  = 1'b1;
            W_stall_o   = 1'b1;
            w_ret_cnt_d = 2'd0;
            w_state_d   = StHalt;
          end else begin
            F_stall_o   = 1'b1;
            D_bubble_o  = 1'b1;
            w_bub_inc   = 1'b1;
            w_ret_cnt_d = r_ret_cnt - 2'd1;
            // The cycle that drains the count to zero is the last bubble.
            if (w_ret_cnt_d == 2'd0) begin
              w_state_d = StRun;
            end
          end
        end
        StHalt: begin
          F_stall_o  = 1'b1;
          D_stall_o  = 1'b1;
          E_bubble_o = 1'b1;
          M_bubble_o = 1'b1;
          W_stall_o  = 1'b1;
          halted_o   = 1'b1;
        end
        default: begin
          w_state_d   = StRun;
          w_ret_cnt_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StRun;
      r_ret_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_d;
      r_ret_cnt <= w_ret_cnt_d;
    end
  end

  y86_sat_cnt #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_cyc_inc),
    .cnt_o (cycle_cnt_o)
  );

  y86_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (stall_cnt_o)
  );

  y86_sat_cnt #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_bub_inc),
    .cnt_o (bubble_cnt_o)
  );

endmodule
